// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one registered adder between NREQ requesters (optional watchdog: ADDER_ARB_TIMEOUT_EN)
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] opa,
    input  logic [NREQ*WIDTH-1:0] opb,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  res_valid,
    output logic [WIDTH:0]        res,
    output logic [IDW-1:0]        res_id,
    input  logic                  res_ack,
    output logic                  err
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("adder_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("adder_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   ptr_nxt;
    logic             found;
    logic [WIDTH-1:0] opa_l;
    logic [WIDTH-1:0] opb_l;
    logic             timeout;
    logic             done_ev;

    // Round-robin search: first requester at or after ptr, wrapping mod NREQ
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign done_ev = (state == DONE) && (res_ack || timeout);

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; an ack and a watchdog expiry both end the transaction
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   state_nxt = DONE;
            DONE:    if (done_ev) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state so clear removes them at once
    always_comb begin
        gnt = '0;
        if (state == GRANT) gnt[win] = 1'b1;
        busy      = (state != IDLE);
        res_valid = (state == DONE);
    end

    // Operand capture, registered add and round-robin pointer update
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ptr    <= '0;
            win    <= '0;
            opa_l  <= '0;
            opb_l  <= '0;
            res    <= '0;
            res_id <= '0;
        end else begin
            if (state == IDLE && found) begin
                win   <= pick;
                opa_l <= opa[int'(pick)*WIDTH +: WIDTH];
                opb_l <= opb[int'(pick)*WIDTH +: WIDTH];
            end
            if (state == GRANT) begin
                res    <= {1'b0, opa_l} + {1'b0, opb_l};
                res_id <= win;
            end
            if (done_ev) ptr <= ptr_nxt;
        end
    end

`ifdef ADDER_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // Expiry is the edge on which the un-acked count would reach TIMEOUT
    assign timeout = (state == DONE) && !res_ack && (cnt == CW'(TIMEOUT - 1));

    // Watchdog counter restarts on entry to DONE; err is a one-cycle pulse
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= timeout;
            if (state == GRANT)
                cnt <= '0;
            else if (state == DONE && !res_ack)
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter
module tb_adder_arbiter;

    logic        clk;
    logic        clear;
    logic [3:0]  req;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [3:0]  gnt;
    logic        busy;
    logic        res_valid;
    logic [8:0]  res;
    logic [1:0]  res_id;
    logic        res_ack;
    logic        err;

    int checks = 0;
    int errors = 0;

    adder_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .clear(clear), .req(req), .opa(opa), .opb(opb),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res(res),
        .res_id(res_id), .res_ack(res_ack), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_id;
        logic [8:0]  exp_res;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [8:0] hold_res;

    initial begin
        // ptr evolves 0 ->2 ->1 ->2 ->0 ->1 ->3 across the table
        vecs[0] = '{4'b0010, 32'h4433FF11, 32'h05060107, 4'b0010, 2'd1, 9'h100};
        vecs[1] = '{4'b0011, 32'h10203080, 32'h01020380, 4'b0001, 2'd0, 9'h100};
        vecs[2] = '{4'b0011, 32'h00001200, 32'h00003400, 4'b0010, 2'd1, 9'h046};
        vecs[3] = '{4'b1001, 32'hAA000001, 32'h55000001, 4'b1000, 2'd3, 9'h0FF};
        vecs[4] = '{4'b1001, 32'hAA000000, 32'h55000000, 4'b0001, 2'd0, 9'h000};
        vecs[5] = '{4'b0100, 32'h00FF0000, 32'h00FF0000, 4'b0100, 2'd2, 9'h1FE};

        clear = 1'b1; req = '0; opa = '0; opb = '0; res_ack = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_res", 32'(res), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_err", 32'(err), 0);
        tick();
        clear = 1'b0;
        tick();
        chk("idle_gnt", 32'(gnt), 0);

        for (int v = 0; v < 6; v++) begin
            req = vecs[v].req; opa = vecs[v].opa; opb = vecs[v].opb;
            tick();
            chk($sformatf("v%0d_gnt", v), 32'(gnt), 32'(vecs[v].exp_gnt));
            chk($sformatf("v%0d_busy", v), 32'(busy), 1);
            req = '0;
            tick();
            chk($sformatf("v%0d_gnt_off", v), 32'(gnt), 0);
            chk($sformatf("v%0d_valid", v), 32'(res_valid), 1);
            chk($sformatf("v%0d_res", v), 32'(res), 32'(vecs[v].exp_res));
            chk($sformatf("v%0d_id", v), 32'(res_id), 32'(vecs[v].exp_id));
            chk($sformatf("v%0d_err", v), 32'(err), 0);
            res_ack = 1'b1;
            tick();
            chk($sformatf("v%0d_valid_off", v), 32'(res_valid), 0);
            chk($sformatf("v%0d_idle", v), 32'(busy), 0);
            res_ack = 1'b0;
        end

        // Hold in DONE without ack; req/operand changes must not leak in (ptr=3)
        req = 4'b0001; opa = 32'h00000037; opb = 32'h00000021;
        tick();
        chk("hold_gnt", 32'(gnt), 32'h1);
        req = 4'b1110; opa = 32'hFFFFFFFF; opb = 32'hFFFFFFFF;
        tick();
        chk("hold_res0", 32'(res), 32'h058);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_res", 32'(res), 32'h058);
            chk("hold_id", 32'(res_id), 0);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_gnt_off", 32'(gnt), 0);
        end
        req = '0; res_ack = 1'b1;
        tick();
        chk("hold_ack_valid", 32'(res_valid), 0);
        res_ack = 1'b0;

        // clear asserted mid-cycle while in GRANT (ptr=1 beforehand)
        req = 4'b0100; opa = 32'h00050000; opb = 32'h00060000;
        tick();
        chk("clr_pre_gnt", 32'(gnt), 32'h4);
        req = '0;
        #2 clear = 1'b1;
        #1;
        chk("clr_gnt", 32'(gnt), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_valid", 32'(res_valid), 0);
        chk("clr_res", 32'(res), 0);
        tick();
        clear = 1'b0;
        req = 4'b0011; opa = 32'h00000203; opb = 32'h00000405;
        tick();
        chk("clr_ptr0_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("clr_ptr0_res", 32'(res), 32'h008);
        chk("clr_ptr0_valid", 32'(res_valid), 1);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;

        // Reset ptr, then back-to-back with ack held: grants 0,1,2,3,0 every 3 cycles
        clear = 1'b1;
        tick();
        clear = 1'b0;
        req = 4'b1111; opa = 32'h40302010; opb = 32'h04030201; res_ack = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("b2b%0d_gnt", n), 32'(gnt), 32'(1 << (n % 4)));
            tick();
            chk($sformatf("b2b%0d_valid", n), 32'(res_valid), 1);
            chk($sformatf("b2b%0d_id", n), 32'(res_id), 32'(n % 4));
            chk($sformatf("b2b%0d_res", n), 32'(res), 32'(9'h011 * ((n % 4) + 1)));
            tick();
            chk($sformatf("b2b%0d_gap", n), 32'(gnt | {3'b0, res_valid}), 0);
        end
        req = '0; res_ack = 1'b0;
        tick();

`ifdef ADDER_ARB_TIMEOUT_EN
        // ptr=1: watchdog expiry drops the result and grants the next requester
        req = 4'b0011; opa = 32'h00000100; opb = 32'h00000100;
        tick();
        chk("to_gnt", 32'(gnt), 32'h2);
        tick();
        chk("to_valid", 32'(res_valid), 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_wait_err", 32'(err), 0);
            chk("to_wait_valid", 32'(res_valid), 1);
        end
        tick();
        chk("to_err", 32'(err), 1);
        chk("to_valid_off", 32'(res_valid), 0);
        tick();
        chk("to_err_off", 32'(err), 0);
        chk("to_next_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("to2_valid", 32'(res_valid), 1);
        for (int i = 1; i < 16; i++) tick();
        res_ack = 1'b1;
        tick();
        chk("to2_valid_off", 32'(res_valid), 0);
        chk("to2_err", 32'(err), 0);
        res_ack = 1'b0;
        tick();
        chk("to2_err_after", 32'(err), 0);
`else
        chk("err_tied", 32'(err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit adder (sum = a + b, WIDTH+1-bit result) between NREQ requesters. It captures the winning requester's operands and performs the addition in a registered stage. It holds the tagged result until the consumer acknowledges it. It sits in front of the test adder datapath, replacing direct drive of `a`/`b` by a single testbench source.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand width
- `TIMEOUT`, 16, result-ack watchdog limit in cycles (used only with `ADDER_ARB_TIMEOUT_EN`)

- `clk`  input  1  clock, rising edge
- `clear`  input  1  reset, asynchronous, active-high
- `req`  input  NREQ  per-requester request, level
- `opa`  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `opb`  input  NREQ*WIDTH  operand B, same packing
- `gnt`  output  NREQ  one-hot grant pulse; operands captured
- `busy`  output  1  high in any state other than IDLE
- `res_valid`  output  1  result available
- `res`  output  WIDTH+1  opa + opb of the granted requester, carry in MSB
- `res_id`  output  log2(NREQ) (min 1)  index of the requester that owns `res`
- `res_ack`  input  1  consumer accepts result
- `err`  output  1  one-cycle watchdog pulse (constant 0 without the macro)

## Operation
- FSM states: IDLE, GRANT, DONE. Reset state is IDLE.
- IDLE: when `req` != 0, pick the winner by round-robin search starting at `ptr`, then `ptr+1`, … mod NREQ. Latch the winner's opa/opb and its index, drive `gnt` one-hot to the winner, and go to GRANT. When `req` == 0, stay.
- GRANT: `res` <= opa_l + opb_l, zero-extended to WIDTH+1 with no truncation. `res_id` <= winner. `res_valid` <= 1. `gnt` <= 0. Go to DONE.
- DONE: hold `res`, `res_id` and `res_valid` stable. On an edge with `res_ack`=1, set `res_valid` <= 0, `ptr` <= (winner+1) mod NREQ, and go to IDLE.
- Requester rules: hold `req` and operands stable until `gnt` is seen. Drop `req` after `gnt` or re-assert it for a new operation. `req` deasserted before a grant is ignored and has no side effect.
- `req` changes while in GRANT/DONE are not sampled. Operands are taken only at the IDLE→GRANT edge.
- `res_ack` is ignored outside DONE.
- `ptr` advances only on a completed transaction. A requester that is always requesting therefore cannot starve the others.

## Timing
- Reset values: `gnt`=0, `busy`=0, `res_valid`=0, `res`=0, `res_id`=0, `err`=0, `ptr`=0, state IDLE. These take effect immediately on `clear` without waiting for `clk`.
- `req` sampled at edge k produces `gnt` high during cycle k→k+1 (exactly one cycle), and `res_valid` high from edge k+1.
- `res_ack` sampled high at edge m makes `res_valid` low from edge m. IDLE can issue the next grant at edge m+1.
- Minimum spacing is one operation per 3 cycles. With a consumer that holds `res_ack` high, back-to-back grants occur every 3 cycles.
- `busy` = (state != IDLE), registered with the state.
- `clear` mid-operation: the in-flight result is discarded and all outputs return to reset values. No partial `gnt` or `res_valid` pulse survives.

## Configuration
- `ADDER_ARB_TIMEOUT_EN` defined: a counter starts at 0 on entry to DONE and increments each cycle without `res_ack`. When it reaches TIMEOUT with no ack:
  - drop the result: `res_valid` <= 0, state <= IDLE, `ptr` advances as for an ack;
  - pulse `err` high for one cycle.
- An ack on the same edge the counter hits TIMEOUT wins: normal completion, no `err`.
- `ADDER_ARB_TIMEOUT_EN` undefined: no counter is built. DONE waits indefinitely and `err` is tied to 0.

## Test plan
- Reset, then req=4'b0010 with opa1=8'hFF, opb1=8'h01 → gnt=4'b0010 for one cycle; res=9'h100, res_id=1, res_valid held until res_ack.
- req=4'b1111 held high, res_ack tied 1, distinct operands per requester → grant order 0,1,2,3,0, spaced every 3 cycles; each res matches the sum for its res_id.
- res_ack held 0 for 10 cycles in DONE → res, res_id and res_valid remain stable; req changes and operand changes during this time have no effect; ack → res_valid low next edge.
- clear asserted mid-clock while in GRANT → outputs zero immediately; after release, req=4'b0001 is granted with ptr=0 behaviour.
- With `ADDER_ARB_TIMEOUT_EN`, TIMEOUT=16, no ack → 16 cycles after entering DONE, err pulses one cycle, res_valid drops, and the next requester (ptr+1) is granted. A second run with res_ack at cycle 16 → completes normally with err=0.
- opa=opb=8'h80 → res=9'h100; opa=opb=0 → res=0 with res_valid still asserted.
